// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder for the MEM-stage port
// Optional: define DMEM_ACCESS_COUNT_EN to add the saturating AccessCount output.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2,
  parameter int TEST_ADDR   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic [31:0] Addr,
  input  logic [31:0] Data_i,
  output logic [31:0] Data,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr,
  output logic [31:0] TestPort
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] AccessCount
`endif
);

  localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]            WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [DEPTH_LOG2-1:0] TEST_IDX = DEPTH_LOG2'(TEST_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [31:0]             data_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    req_err;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    load_data;
  logic [DEPTH_LOG2-1:0]   load_idx;
  logic                    load_err;

  assign req_idx = Addr[DEPTH_LOG2+1:2];
  assign req_err = (Addr[1:0] != 2'b00) || ((Addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  // With zero wait states the read completes straight from IDLE, so the
  // load source is the live request rather than the latched one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    load_data = 1'b0;
    load_idx  = idx_q;
    load_err  = err_q;
    case (state_q)
      IDLE: begin
        if (ReadMem || WriteMem) begin
          idx_d   = req_idx;
          wdata_d = Data_i;
          wr_d    = WriteMem;
          err_d   = req_err;
          cnt_d   = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            state_d   = RESP;
            load_data = !WriteMem;
            load_idx  = req_idx;
            load_err  = req_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d   = RESP;
          load_data = !wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      if (load_data) data_q <= load_err ? 32'd0 : mem_q[load_idx];
      if (state_q == RESP && wr_q && !err_q) mem_q[idx_q] <= wdata_q;
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] acc_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_cnt_q <= 16'd0;
    else if (state_q == RESP && acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
  end

  assign AccessCount = acc_cnt_q;
`endif

  assign Data     = data_q;
  assign Ready    = (state_q == RESP);
  assign Busy     = (state_q != IDLE);
  assign AddrErr  = (state_q == RESP) && err_q;
  assign TestPort = mem_q[TEST_IDX];

endmodule
